nw_path_reader: RTL and testbench
=================================

Name: nw_path_reader

Overview:
- Consumer of the traceback coordinate stream produced by the NW grid. Coordinates arrive end-to-start: (LENGTH-1,LENGTH-1) down to (0,0).
- Buffers the path in a LIFO, checks each step is legal, then replays it start-to-end as aligned character columns with gap flags.
- Accumulates the alignment score from the same weights as the grid.
- Sits between the grid traceback and the host/output formatter.

Parameters:
- LENGTH, 10, characters per string.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, score width (signed).
- CORD_LENGTH, 8, bits per coordinate.
- MATCH, 1, signed weight for a matching pair.
- MISMATCH, -1, signed weight for a non-matching pair.
- INDEL, -1, signed weight for a gap column.
- DEPTH, 2*LENGTH-1, LIFO entries (maximum path length).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- s1  in  LENGTH*CWIDTH  string 1; char j at [(LENGTH-1-j)*CWIDTH +: CWIDTH]; indexed by y.
- s2  in  LENGTH*CWIDTH  string 2; char k at [(LENGTH-1-k)*CWIDTH +: CWIDTH]; indexed by x.
- start  in  1  arms the block (from IDLE, DONE or ERR).
- in_valid  in  1  coordinate present.
- in_x  in  CORD_LENGTH  x coordinate.
- in_y  in  CORD_LENGTH  y coordinate.
- in_ready  out  1  coordinate accepted when in_valid && in_ready.
- out_valid  out  1  aligned column present.
- out_ready  in  1  downstream accepts the column.
- out_c1  out  CWIDTH  s1 character (0 when out_gap1).
- out_c2  out  CWIDTH  s2 character (0 when out_gap2).
- out_gap1  out  1  gap in s1 for this column.
- out_gap2  out  1  gap in s2 for this column.
- out_last  out  1  final column.
- score  out  SWIDTH  signed accumulated score; final when done=1.
- done  out  1  alignment fully emitted.
- error  out  1  malformed path detected.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; LIFO empty; score=0; all other outputs 0.
- IDLE:
  - in_ready=0.
  - start -> LOAD; clears score and LIFO.
- LOAD:
  - in_ready=1; each handshake pushes (x,y).
  - First coordinate must be (LENGTH-1,LENGTH-1).
  - Each later coordinate must be (px-1,py), (px,py-1) or (px-1,py-1) relative to the previous one, with no negative values.
  - Any violation, or a push when the LIFO holds DEPTH entries, -> ERR on that edge; the offending coordinate is not pushed.
  - Accepting (0,0) -> EMIT on the same edge.
  - start is ignored in LOAD.
- EMIT:
  - Pops one entry per column. The pop order is (0,0) first, up to the corner.
  - Column 0 is the pair (s1[0],s2[0]).
  - For each forward step (x,y)->(x',y'):
    - diagonal: pair (s1[y'], s2[x']).
    - x only: out_gap1=1, out_c2=s2[x'].
    - y only: out_gap2=1, out_c1=s1[y'].
  - out_valid rises on the first edge after entering EMIT.
  - A new column is presented each cycle that out_ready=1.
  - While out_valid && !out_ready, all out_* fields and score hold stable.
  - Score is updated on each accepted column: +MATCH for an equal pair, +MISMATCH for an unequal pair, +INDEL for a gap. Arithmetic is sign-extended to SWIDTH and wraps with no saturation.
  - out_last=1 on the column of the corner entry.
  - Accepting the last column -> DONE; out_valid drops on the same edge.
  - Total columns = number of coordinates pushed.
- DONE:
  - done=1; score holds the final value.
  - start -> LOAD (clears done, score and LIFO).
- ERR:
  - error=1; in_ready=0; out_valid=0.
  - start -> LOAD (clears error).
- s1/s2 must stay stable from start until done or error; sampling is combinational during EMIT.
- A coordinate ≥ LENGTH is an error.
- Reset mid-operation aborts immediately; no partial output is retained.

Test Plan:
- LENGTH=4, s1=s2={0,1,2,3}; push (3,3),(2,2),(1,1),(0,0); out_ready=1 -> 4 pair columns (0,0),(1,1),(2,2),(3,3); out_last on the 4th; score=4; done=1.
- Same strings; push (3,3),(3,2),(2,1),(1,0),(0,0) -> 5 columns: pair(0,0); gap1 c2=1; pair(1,2); pair(2,3); gap2 c1=3; score=-3.
- Repeat the first case with out_ready alternating 1,0 -> each column held for its stall cycle; exactly 4 accepted columns; same score=4.
- First coordinate (2,3) -> error=1 next edge, in_ready=0, no out_valid; then start -> in_ready=1, error=0.
- Push (3,3) then (1,1) -> ERR; LIFO not emitted.
- Assert reset=0 during EMIT after 2 columns -> out_valid=0, score=0, done=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/nw_path_reader.sv
// Needleman-Wunsch traceback reader: buffers the end-to-start coordinate path in a
// LIFO, validates each step, then replays it start-to-end as scored alignment columns.
module nw_path_reader #(
    parameter int        LENGTH      = 10,
    parameter int        CWIDTH      = 2,
    parameter int        SWIDTH      = 16,
    parameter int        CORD_LENGTH = 8,
    parameter int signed MATCH       = 1,
    parameter int signed MISMATCH    = -1,
    parameter int signed INDEL       = -1,
    parameter int        DEPTH       = 2*LENGTH-1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [CORD_LENGTH-1:0]   in_x,
    input  logic [CORD_LENGTH-1:0]   in_y,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_gap1,
    output logic                     out_gap2,
    output logic                     out_last,
    output logic signed [SWIDTH-1:0] score,
    output logic                     done,
    output logic                     error
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CORD_LENGTH-1:0] CORNER = CORD_LENGTH'(LENGTH-1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] EMIT = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]                   state;
    logic [2*CORD_LENGTH-1:0]     lifo [DEPTH];
    logic [CNT_W-1:0]             count;
    logic [CORD_LENGTH-1:0]       prev_x, prev_y;
    logic                         first_col;

    logic                         dec_x, dec_y, same_x, same_y, step_ok, push_ok, push_en;
    logic [CNT_W-1:0]             top_idx;
    logic [CORD_LENGTH-1:0]       top_x, top_y;
    logic                         advance;
    logic                         col_gap1, col_gap2;
    logic [CWIDTH-1:0]            col_c1, col_c2;
    logic signed [SWIDTH-1:0]     weight;

    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                  input logic [CORD_LENGTH-1:0]   idx);
        char_at = '0;
        for (int j = 0; j < LENGTH; j++)
            if (idx == CORD_LENGTH'(j)) char_at = str[(LENGTH-1-j)*CWIDTH +: CWIDTH];
    endfunction

    assign in_ready = (state == LOAD);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        dec_x   = (prev_x != '0) && (in_x == prev_x - CORD_LENGTH'(1));
        dec_y   = (prev_y != '0) && (in_y == prev_y - CORD_LENGTH'(1));
        same_x  = (in_x == prev_x);
        same_y  = (in_y == prev_y);
        step_ok = 1'b0;
        if (count == '0)
            step_ok = (in_x == CORNER) && (in_y == CORNER);
        else
            step_ok = (dec_x && same_y) || (same_x && dec_y) || (dec_x && dec_y);
        push_ok = step_ok && (in_x <= CORNER) && (in_y <= CORNER) && (count != CNT_W'(DEPTH));
        push_en = (state == LOAD) && in_valid && push_ok;
    end

    // The first popped entry is always (0,0) and forms a plain pair column.
    always_comb begin
        top_idx  = (count == '0) ? '0 : count - CNT_W'(1);
        top_x    = lifo[top_idx][2*CORD_LENGTH-1:CORD_LENGTH];
        top_y    = lifo[top_idx][CORD_LENGTH-1:0];
        advance  = (state == EMIT) && (!out_valid || out_ready) && (count != '0);
        col_gap1 = !first_col && (top_x != prev_x) && (top_y == prev_y);
        col_gap2 = !first_col && (top_x == prev_x) && (top_y != prev_y);
        col_c1   = col_gap1 ? '0 : char_at(s1, top_y);
        col_c2   = col_gap2 ? '0 : char_at(s2, top_x);
        if (out_gap1 || out_gap2)
            weight = SWIDTH'(INDEL);
        else if (out_c1 == out_c2)
            weight = SWIDTH'(MATCH);
        else
            weight = SWIDTH'(MISMATCH);
    end

    // NOTE: path storage is left unreset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) lifo[count] <= {in_x, in_y};
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            prev_x    <= '0;
            prev_y    <= '0;
            first_col <= 1'b0;
            score     <= '0;
            out_valid <= 1'b0;
            out_c1    <= '0;
            out_c2    <= '0;
            out_gap1  <= 1'b0;
            out_gap2  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LOAD;
                        count     <= '0;
                        score     <= '0;
                        out_valid <= 1'b0;
                        out_c1    <= '0;
                        out_c2    <= '0;
                        out_gap1  <= 1'b0;
                        out_gap2  <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (!push_ok) begin
                            state <= ERR;
                        end else begin
                            count  <= count + CNT_W'(1);
                            prev_x <= in_x;
                            prev_y <= in_y;
                            if (in_x == '0 && in_y == '0) begin
                                state     <= EMIT;
                                first_col <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        score <= score + weight;
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                        end
                    end
                    if (advance) begin
                        out_valid <= 1'b1;
                        out_c1    <= col_c1;
                        out_c2    <= col_c2;
                        out_gap1  <= col_gap1;
                        out_gap2  <= col_gap2;
                        out_last  <= (count == CNT_W'(1));
                        count     <= count - CNT_W'(1);
                        prev_x    <= top_x;
                        prev_y    <= top_y;
                        first_col <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_path_reader.sv
// Bench for nw_path_reader (LENGTH=4): table of paths with hand-derived columns fed
// through a scoreboard queue, plus error and mid-emit reset sequences.
module tb_nw_path_reader;

    localparam int L  = 4;
    localparam int CW = 2;
    localparam int CL = 8;
    localparam int SW = 16;

    typedef struct packed {
        logic          g1;
        logic          g2;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
        logic          last;
    } col_t;

    typedef struct packed {
        int               n;
        logic [6:0][7:0]  xs;
        logic [6:0][7:0]  ys;
        logic             stall;
        int               exp_score;
        int               ncols;
        col_t [6:0]       cols;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [L*CW-1:0]      s1, s2;
    logic                 start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CL-1:0]        in_x = '0, in_y = '0;
    logic                 in_ready, out_valid, out_gap1, out_gap2, out_last, done, error;
    logic [CW-1:0]        out_c1, out_c2;
    logic signed [SW-1:0] score;

    int   total = 0;
    int   passed = 0;
    col_t sb[$];
    vec_t vecs[3];

    nw_path_reader #(.LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)) dut (
        .clk(clk), .reset(reset), .s1(s1), .s2(s2), .start(start),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
        .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last),
        .score(score), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add_coord(input int v, input int x, input int y);
        vecs[v].xs[vecs[v].n] = 8'(x);
        vecs[v].ys[vecs[v].n] = 8'(y);
        vecs[v].n++;
    endtask

    task automatic add_col(input int v, input logic g1, input logic g2,
                           input int c1, input int c2, input logic last);
        vecs[v].cols[vecs[v].ncols] = {g1, g2, 2'(c1), 2'(c2), last};
        vecs[v].ncols++;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic load_path(input int v);
        for (int i = 0; i < vecs[v].n; i++) begin
            in_valid = 1'b1;
            in_x = vecs[v].xs[i];
            in_y = vecs[v].ys[i];
            check("in_ready_load", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        int         accepted;
        logic       stalled;
        logic [22:0] held;
        col_t       got;
        accepted = 0;
        stalled  = 1'b0;
        held     = '0;
        pulse_start();
        for (int i = 0; i < vecs[v].ncols; i++) sb.push_back(vecs[v].cols[i]);
        load_path(v);
        check("out_valid_first_emit_cycle", out_valid, 0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (stalled)
                check("hold_during_stall", {out_gap1, out_gap2, out_c1, out_c2, out_last, score}, held);
            out_ready = 1'b1;
            if (out_valid && vecs[v].stall && !stalled) begin
                out_ready = 1'b0;
                stalled   = 1'b1;
                held      = {out_gap1, out_gap2, out_c1, out_c2, out_last, score};
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                accepted++;
                got = {out_gap1, out_gap2, out_c1, out_c2, out_last};
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) check("column", got, sb.pop_front());
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("done", done, 1);
        check("score", score, vecs[v].exp_score);
        check("accepted_columns", accepted, vecs[v].ncols);
        check("sb_drained", sb.size(), 0);
        check("out_valid_after_done", out_valid, 0);
    endtask

    initial begin
        int acc;
        s1 = {2'd0, 2'd1, 2'd2, 2'd3};
        s2 = {2'd0, 2'd1, 2'd2, 2'd3};

        // Path table: coordinates end-to-start, expected columns start-to-end.
        for (int v = 0; v < 3; v++) vecs[v] = '0;
        add_coord(0, 3, 3); add_coord(0, 2, 2); add_coord(0, 1, 1); add_coord(0, 0, 0);
        add_col(0, 0, 0, 0, 0, 0); add_col(0, 0, 0, 1, 1, 0);
        add_col(0, 0, 0, 2, 2, 0); add_col(0, 0, 0, 3, 3, 1);
        vecs[0].exp_score = 4;

        add_coord(1, 3, 3); add_coord(1, 3, 2); add_coord(1, 2, 1);
        add_coord(1, 1, 0); add_coord(1, 0, 0);
        add_col(1, 0, 0, 0, 0, 0); add_col(1, 1, 0, 0, 1, 0); add_col(1, 0, 0, 1, 2, 0);
        add_col(1, 0, 0, 2, 3, 0); add_col(1, 0, 1, 3, 0, 1);
        vecs[1].exp_score = -3;

        vecs[2] = vecs[0];
        vecs[2].stall = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_score", score, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) run_vec(v);

        // Wrong first coordinate.
        pulse_start();
        in_valid = 1'b1; in_x = 8'd2; in_y = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("bad_first_error", error, 1);
        check("bad_first_in_ready", in_ready, 0);
        check("bad_first_out_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        check("err_no_output", out_valid, 0);
        pulse_start();
        check("restart_in_ready", in_ready, 1);
        check("restart_error_clear", error, 0);

        // Illegal step (3,3)->(1,1).
        in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
        @(negedge clk);
        in_x = 8'd1; in_y = 8'd1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bad_step_error", error, 1);
        check("bad_step_done", done, 0);
        repeat (4) @(negedge clk);
        check("bad_step_no_output", out_valid, 0);

        // Reset during emission after two accepted columns.
        pulse_start();
        load_path(0);
        out_ready = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
            if (out_valid && out_ready) acc++;
            @(negedge clk);
        end
        check("mid_score_before_reset", score, 2);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_score", score, 0);
        check("abort_done", done, 0);
        out_ready = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_error", error, 0);

        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
